// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, FSM states and ALU helpers shared by the multicycle MIPS core
package mips_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_BRANCH, S_EXEC_R, S_EXEC_I, S_WB_ALU,
    S_MEM_ADR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_HALT
  } state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
  function automatic alu_op_t alu_op_of(input logic [5:0] fn);
    return fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND :
           fn == FN_OR ? ALU_OR : fn == FN_SLT ? ALU_SLT : ALU_ADD;
  endfunction
  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    return op == ALU_SUB ? a - b : op == ALU_AND ? a & b : op == ALU_OR ? a | b :
           op == ALU_SLT ? {31'b0, $signed(a) < $signed(b)} : a + b;
  endfunction
endpackage

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle FSM; ports: clk/rst, opcode+funct of IR, mem handshake in,
// current state plus registered mem_read/mem_write/illegal and the retire pulse out.
module mips_mc_ctrl import mips_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  output state_t     state_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       retire_o,
  output logic       illegal_o
);
  state_t state_q, state_d;
  logic xfer, r_ok, jump;
  assign xfer = mem_ready_i & (mem_read_o | mem_write_o);
  assign r_ok = funct_i inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  assign jump = op_i == OP_J || op_i == OP_JAL || (op_i == OP_R && funct_i == FN_JR);
  assign state_o = state_q;
  // an instruction ends on whichever cycle hands control back to FETCH
  assign retire_o = state_q != S_FETCH && state_d == S_FETCH;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = xfer ? S_DECODE : S_FETCH;
      S_DECODE: state_d = jump ? S_FETCH : op_i == OP_BEQ ? S_BRANCH :
                          (op_i == OP_R && r_ok) ? S_EXEC_R :
                          (op_i == OP_ADDI || op_i == OP_SLTI) ? S_EXEC_I :
                          (op_i == OP_LW || op_i == OP_SW) ? S_MEM_ADR : S_HALT;
      S_BRANCH, S_WB_ALU, S_WB_MEM: state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADR: state_d = op_i == OP_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: state_d = xfer ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: state_d = xfer ? S_FETCH : S_MEM_WR;
      default: state_d = S_HALT;
    endcase
  end
  // requests are registered from the next state, so the first fetch after reset
  // spends one cycle raising mem_read before the handshake can complete
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= S_FETCH;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      illegal_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_read_o  <= state_d == S_FETCH || state_d == S_MEM_RD;
      mem_write_o <= state_d == S_MEM_WR;
      illegal_o   <= state_d == S_HALT;
    end
endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS-I subset core with one shared ready-handshake memory port;
// ports: clk/rst, mem_addr/mem_wdata/mem_read/mem_write out, mem_rdata/mem_ready in,
// pc_out, retire pulse and sticky illegal-halt flag out.
module mips_multicycle_core import mips_pkg::*; #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          RF_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_ready,
  output logic [31:0]       pc_out,
  output logic              retire,
  output logic              illegal
);
  state_t state;
  logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q, sext, rs_v, rt_v, wd;
  logic [31:0] rf_q [32];
  logic [5:0] op, fn;
  logic [4:0] wa;
  logic we, xfer;
  mips_mc_ctrl u_ctrl (
    .clk(clk), .rst(rst), .op_i(op), .funct_i(fn), .mem_ready_i(mem_ready),
    .state_o(state), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .retire_o(retire), .illegal_o(illegal)
  );
  assign op = ir_q[31:26];
  assign fn = ir_q[5:0];
  assign sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign rs_v = ir_q[25:21] == 5'd0 ? '0 : rf_q[ir_q[25:21]];
  assign rt_v = ir_q[20:16] == 5'd0 ? '0 : rf_q[ir_q[20:16]];
  assign xfer = mem_ready & (mem_read | mem_write);
  assign mem_addr = state == S_FETCH ? {pc_q[ADDR_W-1:2], 2'b00} : {alu_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = b_q;
  assign pc_out = pc_q;
  // jal links in DECODE (pc already +4); WB_ALU targets rd for R-type, rt otherwise
  assign we = (state == S_DECODE && op == OP_JAL) || state == S_WB_ALU || state == S_WB_MEM;
  assign wa = state == S_DECODE ? 5'd31 : (state == S_WB_ALU && op == OP_R) ? ir_q[15:11] : ir_q[20:16];
  assign wd = state == S_DECODE ? pc_q : state == S_WB_MEM ? mdr_q : alu_q;
  generate
    if (RF_RESET) begin : g_rf_rst
      always_ff @(posedge clk or posedge rst)
        if (rst) rf_q <= '{default: '0};
        else if (we && wa != 5'd0) rf_q[wa] <= wd;
    end else begin : g_rf
      always_ff @(posedge clk)
        if (we && wa != 5'd0) rf_q[wa] <= wd;
    end
  endgenerate
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr_q <= '0;
    end else begin
      case (state)
        S_FETCH: if (xfer) begin
          ir_q <= mem_rdata;
          pc_q <= pc_q + 32'd4;
        end
        S_DECODE: begin
          a_q   <= rs_v;
          b_q   <= rt_v;
          alu_q <= pc_q + (sext << 2);
          if (op == OP_J || op == OP_JAL) pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
          else if (op == OP_R && fn == FN_JR) pc_q <= rs_v;
        end
        S_BRANCH: if (a_q == b_q) pc_q <= alu_q;
        S_EXEC_R: alu_q <= alu(alu_op_of(fn), a_q, b_q);
        S_EXEC_I: alu_q <= alu(op == OP_SLTI ? ALU_SLT : ALU_ADD, a_q, sext);
        S_MEM_ADR: alu_q <= a_q + sext;
        S_MEM_RD: if (xfer) mdr_q <= mem_rdata;
        default: ;
      endcase
    end
endmodule
